pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 12: operand and sum width in bits.
REQ-002 SHALL have parameter SLICE, default 6: bits per pipeline slice; WIDTH % SLICE == 0 and SLICE >= 1, checked at elaboration; NSLICE = WIDTH/SLICE.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-007 SHALL have port X, input, WIDTH: operand A.
REQ-008 SHALL have port Y, input, WIDTH: operand B.
REQ-009 SHALL have port Cin, input, 1: carry-in; ignored in SUB mode.
REQ-010 SHALL have port mode, input, 1: 0 = ADD, 1 = SUB (X - Y).
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result when out_valid && out_ready.
REQ-013 SHALL have port S, output, WIDTH: sum or difference.
REQ-014 SHALL have port Co, output, 1: carry-out; in SUB mode 1 = no borrow.
REQ-015 SHALL have port Ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 ADD SHALL compute {Co,S} = X + Y + Cin, modulo 2^(WIDTH+1).
REQ-017 SUB SHALL compute {Co,S} = X + ~Y + 1.
REQ-018 Ovf SHALL be 1 iff the effective operand MSBs are equal and S MSB differs from them.
REQ-019 The carry chain SHALL be split into NSLICE slices.
REQ-020 Slice k SHALL be computed in pipeline stage k from the registered carry of slice k-1.
REQ-021 Not-yet-used operand bits SHALL be skewed through registers; completed sum bits SHALL be delayed to align.
REQ-022 Global advance SHALL be adv = !out_valid || out_ready.
REQ-023 in_ready SHALL equal adv, combinationally.
REQ-024 All stage registers, including per-stage valid bits, SHALL load only when adv = 1.
REQ-025 Latency SHALL be exactly NSLICE cycles from acceptance to out_valid while out_ready is held at 1.
REQ-026 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-027 Bubbles (stages with valid = 0) SHALL propagate and SHALL NOT be collapsed.
REQ-028 While out_valid && !out_ready, S, Co, Ovf and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-029 On simultaneous accept and output handoff in one cycle, both SHALL occur with no loss or duplication.
REQ-030 Results SHALL emerge in acceptance order.
REQ-031 When NSLICE = 1, the block SHALL be a single registered stage with latency 1.
REQ-032 S, Co and Ovf SHALL be registered outputs.
REQ-033 in_ready SHALL be the only combinational output.

Reset
REQ-034 rst_n low SHALL immediately clear all stage valid bits, out_valid, S, Co and Ovf to 0, independent of clk.
REQ-035 Reset asserted mid-operation SHALL discard in-flight beats.
REQ-036 After reset release, in_ready SHALL be 1 and the first accepted beat SHALL appear after NSLICE cycles.
REQ-037 Skew and data registers other than outputs MAY be left unreset; valid bits SHALL NOT.

Structure
REQ-038 Package adder_pkg SHALL hold the mode enum (MODE_ADD = 0, MODE_SUB = 1) and default WIDTH/SLICE constants.
REQ-039 Sub-module cla_slice SHALL be a parametrised SLICE-bit carry-lookahead adder: inputs a, b, ci; outputs s, co.
REQ-040 cla_slice SHALL be instantiated NSLICE times in a generate loop.

Verification (WIDTH = 12, SLICE = 6, latency 2)
REQ-041 ADD X = 0xFFF, Y = 0x001, Cin = 0, out_ready = 1 -> two cycles later S = 0x000, Co = 1, Ovf = 0.
REQ-042 SUB X = 0x800, Y = 0x001 -> S = 0x7FF, Co = 1, Ovf = 1; SUB X = 0x000, Y = 0x001 -> S = 0xFFF, Co = 0, Ovf = 0.
REQ-043 ADD 0x7FF + 0x001 + Cin = 0 -> S = 0x800, Ovf = 1; 0x03F + 0x001 -> S = 0x040, carry crosses the slice boundary.
REQ-044 Five back-to-back beats (i + 0x100*i, i = 1..5) with out_ready = 1 -> five consecutive results in order, one per cycle.
REQ-045 Hold out_ready = 0 for 3 cycles with the pipe full -> in_ready = 0 and outputs stable; on release all beats are delivered in order, none lost or duplicated.
REQ-046 Assert rst_n low with 2 beats in flight -> out_valid = 0 immediately and no stale result after release; a fresh beat 0x123 + 0x111 -> S = 0x234 after 2 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default geometry for the pipelined adder.
package adder_pkg;

   // Operation select: ADD uses Y and Cin, SUB uses ~Y with a forced carry-in of 1.
   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   localparam int DEF_WIDTH = 12;
   localparam int DEF_SLICE = 6;

   // Two's-complement overflow: both effective operand MSBs agree and the sum MSB does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla_slice.sv
// W-bit carry-lookahead adder slice: s = a + b + ci, carry-out on co.
module cla_slice
   import adder_pkg::*;
#(
   parameter int W = DEF_SLICE
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W-1:0] g_s;
   logic [W-1:0] p_s;
   logic [W:0]   c_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Each carry is the flat OR of generate terms gated by the propagate run below it.
   always_comb begin
      logic acc_v;
      logic prop_v;
      acc_v  = 1'b0;
      prop_v = 1'b0;
      c_s    = '0;
      c_s[0] = ci;
      for (int i = 0; i < W; i++) begin
         acc_v  = g_s[i];
         prop_v = p_s[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc_v  = acc_v | (prop_v & g_s[j]);
            prop_v = prop_v & p_s[j];
         end
         c_s[i+1] = acc_v | (prop_v & ci);
      end
   end

   assign s  = p_s ^ c_s[W-1:0];
   assign co = c_s[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into NSLICE slices, one
// slice resolved per stage, with a single global stall (adv) for backpressure.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             Ovf
);

   if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
      $error("pipelined_adder: WIDTH must be a positive multiple of SLICE");
   end

   localparam int NSLICE = WIDTH / SLICE;
   localparam int LAST   = NSLICE - 1;

   logic             adv_s;
   logic [WIDTH-1:0] b_in_s;
   logic             c_in_s;

   // Per-stage state: stage k holds slices 0..k resolved in s_q and the
   // remaining operand bits (skewed) in a_q/b_q; stage LAST is the output.
   logic [NSLICE-1:0] v_q, v_d;
   logic [NSLICE-1:0] c_q, c_d;
   logic [WIDTH-1:0]  a_q [NSLICE];
   logic [WIDTH-1:0]  a_d [NSLICE];
   logic [WIDTH-1:0]  b_q [NSLICE];
   logic [WIDTH-1:0]  b_d [NSLICE];
   logic [WIDTH-1:0]  s_q [NSLICE];
   logic [WIDTH-1:0]  s_d [NSLICE];
   logic              ovf_q, ovf_d;

   // The whole pipe moves unless a finished result is waiting on the consumer.
   assign adv_s    = !v_q[LAST] || out_ready;
   assign in_ready = adv_s;

   // Subtraction is X + ~Y + 1; Cin only matters when adding.
   always_comb begin
      if (mode_e'(mode) == MODE_SUB) begin
         b_in_s = ~Y;
         c_in_s = 1'b1;
      end else begin
         b_in_s = Y;
         c_in_s = Cin;
      end
   end

   for (genvar k = 0; k < NSLICE; k++) begin : g_stage
      logic [WIDTH-1:0] a_prev_s;
      logic [WIDTH-1:0] b_prev_s;
      logic [WIDTH-1:0] s_prev_s;
      logic             c_prev_s;
      logic             v_prev_s;
      logic [SLICE-1:0] sum_s;
      logic             co_s;
      logic [WIDTH-1:0] s_merge_s;

      if (k == 0) begin : g_first
         assign a_prev_s = X;
         assign b_prev_s = b_in_s;
         assign s_prev_s = '0;
         assign c_prev_s = c_in_s;
         assign v_prev_s = in_valid;
      end else begin : g_next
         assign a_prev_s = a_q[k-1];
         assign b_prev_s = b_q[k-1];
         assign s_prev_s = s_q[k-1];
         assign c_prev_s = c_q[k-1];
         assign v_prev_s = v_q[k-1];
      end

      cla_slice #(.W(SLICE)) u_cla (
         .a  (a_prev_s[k*SLICE +: SLICE]),
         .b  (b_prev_s[k*SLICE +: SLICE]),
         .ci (c_prev_s),
         .s  (sum_s),
         .co (co_s)
      );

      // Drop this stage's freshly resolved slice into the running sum.
      always_comb begin
         s_merge_s                    = s_prev_s;
         s_merge_s[k*SLICE +: SLICE]  = sum_s;
      end

      assign a_d[k] = a_prev_s;
      assign b_d[k] = b_prev_s;
      assign s_d[k] = s_merge_s;
      assign c_d[k] = co_s;
      assign v_d[k] = v_prev_s;

      if (k == LAST) begin : g_ovf
         assign ovf_d = signed_ovf(a_prev_s[WIDTH-1], b_prev_s[WIDTH-1], sum_s[SLICE-1]);
      end
   end

   // Stage registers: cleared asynchronously, loaded together only on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < NSLICE; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv_s) begin
         v_q   <= v_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         for (int k = 0; k < NSLICE; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign S         = s_q[LAST];
   assign Co        = c_q[LAST];
   assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=12, SLICE=6, latency 2).
module tb_pipelined_adder;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [11:0] X         = 12'h000;
   logic [11:0] Y         = 12'h000;
   logic        Cin       = 1'b0;
   logic        mode      = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] S;
   logic        Co;
   logic        Ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(12), .SLICE(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .Y         (Y),
      .Cin       (Cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Co        (Co),
      .Ovf       (Ovf)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y,
                        input logic c, input logic m);
      in_valid = v;
      X        = x;
      Y        = y;
      Cin      = c;
      mode     = m;
   endtask

   // One isolated beat: not visible after one edge, visible after two, gone after three.
   task automatic single(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic c, input logic m, input logic [11:0] es,
                         input logic eco, input logic eovf);
      drive(1'b1, x, y, c, m);
      tick();
      drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      check_val({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
      tick();
      check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check_val({tag, "_S"},     {20'd0, S},         {20'd0, es});
      check_val({tag, "_Co"},    {31'd0, Co},        {31'd0, eco});
      check_val({tag, "_Ovf"},   {31'd0, Ovf},       {31'd0, eovf});
      tick();
      check_val({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      // Reset state
      #3;
      check_val("rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_S",     {20'd0, S},         32'd0);
      check_val("rst_Co",    {31'd0, Co},        32'd0);
      check_val("rst_Ovf",   {31'd0, Ovf},       32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Arithmetic corners
      single("add_wrap",   12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      single("sub_ovf",    12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
      single("sub_borrow", 12'h000, 12'h001, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0);
      single("add_ovf",    12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
      single("add_cross",  12'h03F, 12'h001, 1'b0, 1'b0, 12'h040, 1'b0, 1'b0);
      single("add_cin",    12'h0FF, 12'h100, 1'b1, 1'b0, 12'h200, 1'b0, 1'b0);
      single("sub_cin_ig", 12'h005, 12'h003, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0);
      single("add_negovf", 12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

      // Five back-to-back beats: X = i*0x101, Y = i*0x010 -> S = i*0x111
      out_ready = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         if (c < 5) begin
            drive(1'b1, 12'(12'h101 * (c + 1)), 12'(12'h010 * (c + 1)), 1'b0, 1'b0);
         end else begin
            drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
         end
         tick();
         if (c == 0 || c == 6) begin
            check_val("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            check_val("b2b_valid", {31'd0, out_valid}, 32'd1);
            check_val("b2b_S",     {20'd0, S},         32'(12'h111 * c));
         end
      end

      // Backpressure: A and B in flight, C offered while output stalls
      out_ready = 1'b0;
      drive(1'b1, 12'h001, 12'h002, 1'b0, 1'b0);
      tick();
      drive(1'b1, 12'h010, 12'h020, 1'b0, 1'b0);
      tick();
      drive(1'b1, 12'h100, 12'h200, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         check_val("bp_in_ready", {31'd0, in_ready},  32'd0);
         check_val("bp_valid",    {31'd0, out_valid}, 32'd1);
         check_val("bp_S_hold",   {20'd0, S},         32'h003);
         if (c < 3) begin
            tick();
         end else begin
            out_ready = 1'b1;
            #1;
            check_val("bp_release_ready", {31'd0, in_ready}, 32'd1);
         end
      end
      tick();
      drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      check_val("bp_B_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_B_S",     {20'd0, S},         32'h030);
      tick();
      check_val("bp_C_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_C_S",     {20'd0, S},         32'h300);
      tick();
      check_val("bp_empty",   {31'd0, out_valid}, 32'd0);

      // Reset with two beats in flight
      drive(1'b1, 12'h055, 12'h011, 1'b0, 1'b0);
      tick();
      drive(1'b1, 12'h0AA, 12'h011, 1'b0, 1'b0);
      tick();
      drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      check_val("mid_pre_valid", {31'd0, out_valid}, 32'd1);
      check_val("mid_pre_S",     {20'd0, S},         32'h066);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("mid_rst_S",     {20'd0, S},         32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check_val("mid_rel_valid", {31'd0, out_valid}, 32'd0);
      check_val("mid_rel_ready", {31'd0, in_ready},  32'd1);
      tick();
      check_val("mid_no_stale",  {31'd0, out_valid}, 32'd0);
      single("post_rst", 12'h123, 12'h111, 1'b0, 1'b0, 12'h234, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
